// File: rtl/rs_sched_pkg.sv
// Shared constants for the reservation-station slice: default field widths,
// the "no dependency" tag value and the idle op encoding.
package rs_sched_pkg;

  localparam int TAG_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 6;

  // A source tag equal to EMPTY_TAG carries a valid value.
  localparam int EMPTY_TAG = 0;
  localparam int OP_NOP    = 0;

endpackage : rs_sched_pkg

// File: rtl/rs_age_matrix.sv
// Relative-age tracker: age_q[i][j] set means entry i is older than entry j.
// Returns the one-hot oldest entry among the requesters.
module rs_age_matrix #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] oldest_o
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    age_d = age_q;
    if (en_i) begin
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (free_i[i]) age_d[i] = '0;
        // A new entry is younger than everything: its row clears, its column sets.
        for (int k = 0; k < DEPTH; k++) begin
          if (alloc_i[k]) begin
            age_d[k] = '0;
            for (int j = 0; j < DEPTH; j++)
              if (j != k) age_d[j][k] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    oldest_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic older_req;
      older_req = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        if (j != i && req_i[j] && age_q[j][i]) older_req = 1'b1;
      oldest_o[i] = req_i[i] && !older_req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule : rs_age_matrix

// File: rtl/rs_sched.sv
// Reservation station: holds renamed instructions, wakes operands from the CDB
// channels and dispatches the oldest ready entry through a valid/ready register.
module rs_sched
  import rs_sched_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NCDB   = 2,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int IMM_W  = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAG_W-1:0]         in_dest,
  input  logic [OP_W-1:0]          in_op,
  input  logic [TAG_W-1:0]         in_q1,
  input  logic [TAG_W-1:0]         in_q2,
  input  logic [DATA_W-1:0]        in_v1,
  input  logic [DATA_W-1:0]        in_v2,
  input  logic [IMM_W-1:0]         in_imm,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [NCDB-1:0]          cdb_valid,
  input  logic [NCDB*TAG_W-1:0]    cdb_tag,
  input  logic [NCDB*DATA_W-1:0]   cdb_data,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [OP_W-1:0]          ex_op,
  output logic [DATA_W-1:0]        ex_v1,
  output logic [DATA_W-1:0]        ex_v2,
  output logic [IMM_W-1:0]         ex_imm,
  output logic [ADDR_W-1:0]        ex_pc,
  output logic [TAG_W-1:0]         ex_dest,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(EMPTY_TAG);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic [TAG_W-1:0]  q1;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  q2;
    logic [DATA_W-1:0] v2;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] pc;
    logic [TAG_W-1:0]  dest;
  } ex_t;

  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                   input logic [NCDB-1:0] vld,
                                   input logic [NCDB*TAG_W-1:0] tags);
    cdb_hit = 1'b0;
    if (tag != NO_TAG)
      for (int c = 0; c < NCDB; c++)
        if (vld[c] && tags[c*TAG_W +: TAG_W] == tag) cdb_hit = 1'b1;
  endfunction

  // Scanned high to low so the lowest matching channel wins.
  function automatic logic [DATA_W-1:0] cdb_val(input logic [TAG_W-1:0] tag,
                                                input logic [NCDB-1:0] vld,
                                                input logic [NCDB*TAG_W-1:0] tags,
                                                input logic [NCDB*DATA_W-1:0] data);
    cdb_val = '0;
    for (int c = NCDB - 1; c >= 0; c--)
      if (vld[c] && tags[c*TAG_W +: TAG_W] == tag) cdb_val = data[c*DATA_W +: DATA_W];
  endfunction

  function automatic entry_t wake(input entry_t e,
                                  input logic [NCDB-1:0] vld,
                                  input logic [NCDB*TAG_W-1:0] tags,
                                  input logic [NCDB*DATA_W-1:0] data);
    wake = e;
    if (cdb_hit(e.q1, vld, tags)) begin
      wake.v1 = cdb_val(e.q1, vld, tags, data);
      wake.q1 = NO_TAG;
    end
    if (cdb_hit(e.q2, vld, tags)) begin
      wake.v2 = cdb_val(e.q2, vld, tags, data);
      wake.q2 = NO_TAG;
    end
  endfunction

  logic [DEPTH-1:0] busy_q, busy_d;
  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  ex_t              ex_q, ex_d;
  logic             ex_valid_q, ex_valid_d;

  logic [DEPTH-1:0] free_v, alloc_oh, alloc_en, ready_v, sel_oh, free_en;
  logic [IDX_W-1:0] sel_idx;
  logic             accept, load, any_ready;
  entry_t           new_e;

  always_comb begin
    free_v    = ~busy_q;
    alloc_oh  = free_v & (~free_v + DEPTH'(1));
    accept    = in_valid && (|free_v) && rdy && !clear;
    alloc_en  = accept ? alloc_oh : '0;
    for (int i = 0; i < DEPTH; i++)
      ready_v[i] = busy_q[i] && entry_q[i].q1 == NO_TAG && entry_q[i].q2 == NO_TAG;
    any_ready = |ready_v;
    load      = rdy && !clear && (!ex_valid_q || ex_ready);
    free_en   = (load && any_ready) ? sel_oh : '0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel_oh[i]) sel_idx = IDX_W'(i);
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk      (clk),
    .rst      (rst),
    .en_i     (rdy),
    .flush_i  (clear),
    .alloc_i  (alloc_en),
    .free_i   (free_en),
    .req_i    (ready_v),
    .oldest_o (sel_oh)
  );

  always_comb begin
    new_e      = '0;
    new_e.op   = in_op;
    new_e.dest = in_dest;
    new_e.q1   = in_q1;
    new_e.v1   = in_v1;
    new_e.q2   = in_q2;
    new_e.v2   = in_v2;
    new_e.imm  = in_imm;
    new_e.pc   = in_pc;

    busy_d  = busy_q;
    entry_d = entry_q;
    if (rdy) begin
      if (clear) begin
        busy_d = '0;
      end else begin
        busy_d = (busy_q & ~free_en) | alloc_en;
        for (int i = 0; i < DEPTH; i++) begin
          if (alloc_en[i])
            entry_d[i] = wake(new_e, cdb_valid, cdb_tag, cdb_data);
          else if (busy_q[i])
            entry_d[i] = wake(entry_q[i], cdb_valid, cdb_tag, cdb_data);
        end
      end
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (rdy && clear) begin
      ex_valid_d = 1'b0;
    end else if (load) begin
      ex_valid_d = any_ready;
      if (any_ready) begin
        ex_d.op   = entry_q[sel_idx].op;
        ex_d.v1   = entry_q[sel_idx].v1;
        ex_d.v2   = entry_q[sel_idx].v2;
        ex_d.imm  = entry_q[sel_idx].imm;
        ex_d.pc   = entry_q[sel_idx].pc;
        ex_d.dest = entry_q[sel_idx].dest;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_q       <= '{op: OP_W'(OP_NOP), default: '0};
    end else begin
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  // NOTE: entry payload is storage qualified by busy_q, so it carries no reset.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CNT_W'(busy_q[i]);
  end

  assign in_ready = |free_v;
  assign ex_valid = ex_valid_q;
  assign ex_op    = ex_q.op;
  assign ex_v1    = ex_q.v1;
  assign ex_v2    = ex_q.v2;
  assign ex_imm   = ex_q.imm;
  assign ex_pc    = ex_q.pc;
  assign ex_dest  = ex_q.dest;

endmodule : rs_sched

// File: tb/tb_rs_sched.sv
// Directed bench for rs_sched: issue/dispatch, wakeup, bypass, full, clear, reset.
module tb_rs_sched;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, in_valid, in_ready, ex_valid, ex_ready;
  logic [3:0]  in_dest, in_q1, in_q2, ex_dest;
  logic [5:0]  in_op, ex_op;
  logic [31:0] in_v1, in_v2, in_imm, in_pc, ex_v1, ex_v2, ex_imm, ex_pc;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic [4:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rs_sched dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_op     (in_op),
    .in_q1     (in_q1),
    .in_q2     (in_q2),
    .in_v1     (in_v1),
    .in_v2     (in_v2),
    .in_imm    (in_imm),
    .in_pc     (in_pc),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_op     (ex_op),
    .ex_v1     (ex_v1),
    .ex_v2     (ex_v2),
    .ex_imm    (ex_imm),
    .ex_pc     (ex_pc),
    .ex_dest   (ex_dest),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] dest, input logic [3:0] q1, input logic [31:0] v1,
                       input logic [3:0] q2, input logic [31:0] v2);
    in_valid = 1'b1;
    in_dest  = dest;
    in_op    = 6'(dest) + 6'd1;
    in_q1    = q1;
    in_v1    = v1;
    in_q2    = q2;
    in_v2    = v2;
    in_imm   = 32'h1000 + 32'(dest);
    in_pc    = 32'h4000 + 32'(dest);
  endtask

  task automatic issue(input logic [3:0] dest, input logic [3:0] q1, input logic [31:0] v1,
                       input logic [3:0] q2, input logic [31:0] v2);
    drive(dest, q1, v1, q2, v2);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
    in_dest = '0; in_op = '0; in_q1 = '0; in_q2 = '0; in_v1 = '0; in_v2 = '0;
    in_imm = '0; in_pc = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    tick(); tick();
    check("reset_ex_valid", ex_valid, 0);
    check("reset_count", count, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_ex_v1", ex_v1, 0);
    check("reset_ex_dest", ex_dest, 0);
    rst = 1'b0;
    tick();

    // Operand-complete instruction: one cycle to dispatch.
    issue(4'd3, 4'd0, 32'd5, 4'd0, 32'd7);
    check("t1_count_after_accept", count, 1);
    check("t1_ex_idle", ex_valid, 0);
    tick();
    check("t1_ex_valid", ex_valid, 1);
    check("t1_ex_v1", ex_v1, 5);
    check("t1_ex_v2", ex_v2, 7);
    check("t1_ex_dest", ex_dest, 3);
    check("t1_ex_op", ex_op, 4);
    check("t1_ex_pc", ex_pc, 32'h4003);
    check("t1_count_zero", count, 0);
    tick();
    check("t1_ex_drops", ex_valid, 0);

    // Waiting A is overtaken by ready B, then woken by the CDB.
    issue(4'd1, 4'd4, 32'd0, 4'd0, 32'd2);
    issue(4'd2, 4'd0, 32'h10, 4'd0, 32'h20);
    check("t2_nothing_ready", ex_valid, 0);
    tick();
    check("t2_b_first", ex_dest, 2);
    check("t2_b_valid", ex_valid, 1);
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd4}; cdb_data = {32'd0, 32'h99};
    tick();
    cdb_valid = '0;
    check("t2_gap", ex_valid, 0);
    check("t2_count_a", count, 1);
    tick();
    check("t2_a_dest", ex_dest, 1);
    check("t2_a_v1", ex_v1, 32'h99);
    check("t2_a_v2", ex_v2, 2);
    tick();

    // Capture bypass on issue.
    cdb_valid = 2'b10; cdb_tag = {4'd6, 4'd0}; cdb_data = {32'h11, 32'd0};
    issue(4'd5, 4'd0, 32'd3, 4'd6, 32'd0);
    cdb_valid = '0;
    tick();
    check("t3_valid", ex_valid, 1);
    check("t3_v2_bypass", ex_v2, 32'h11);
    check("t3_v1", ex_v1, 3);
    tick();

    // Fill the station with EX stalled, then drain in issue order.
    ex_ready = 1'b0;
    for (int i = 0; i < 17; i++) issue(4'(i), 4'd0, 32'(100 + i), 4'd0, 32'd0);
    check("t4_full_in_ready", in_ready, 0);
    check("t4_full_count", count, 16);
    check("t4_hold_v1", ex_v1, 100);
    drive(4'd14, 4'd0, 32'hEEE, 4'd0, 32'd0);
    tick();
    check("t4_blocked_count", count, 16);
    check("t4_stable_v1", ex_v1, 100);
    check("t4_stable_dest", ex_dest, 0);
    ex_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t4_accept_blocked", count, 15);
    check("t4_drain_1", ex_v1, 101);
    for (int k = 2; k <= 16; k++) begin
      tick();
      check($sformatf("t4_drain_%0d", k), ex_v1, 64'(100 + k));
    end
    check("t4_count_empty", count, 0);
    tick();
    check("t4_idle", ex_valid, 0);

    // Two channels wake two entries; older goes first.
    issue(4'd7, 4'd2, 32'd0, 4'd0, 32'h70);
    issue(4'd8, 4'd0, 32'h30, 4'd5, 32'd0);
    cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd5}; cdb_data = {32'h22, 32'h55};
    tick();
    cdb_valid = '0;
    check("t5_not_yet", ex_valid, 0);
    tick();
    check("t5_older_dest", ex_dest, 7);
    check("t5_older_v1", ex_v1, 32'h22);
    tick();
    check("t5_younger_dest", ex_dest, 8);
    check("t5_younger_v2", ex_v2, 32'h55);
    tick();

    // Duplicate tag on both channels: channel 0 wins.
    issue(4'd9, 4'd9, 32'd0, 4'd0, 32'd1);
    cdb_valid = 2'b11; cdb_tag = {4'd9, 4'd9}; cdb_data = {32'hB2, 32'hA1};
    tick();
    cdb_valid = '0;
    tick();
    check("t5_dup_dest", ex_dest, 9);
    check("t5_dup_low_ch", ex_v1, 32'hA1);
    tick();

    // Flush with five waiting entries and a held dispatch.
    ex_ready = 1'b0;
    for (int i = 0; i < 6; i++) issue(4'(i + 1), 4'd0, 32'(i), 4'd0, 32'd0);
    check("t6_pre_count", count, 5);
    check("t6_pre_valid", ex_valid, 1);
    clear = 1'b1;
    drive(4'd12, 4'd0, 32'd12, 4'd0, 32'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("t6_clear_count", count, 0);
    check("t6_clear_valid", ex_valid, 0);
    check("t6_clear_in_ready", in_ready, 1);
    tick();
    check("t6_accept_discarded", count, 0);

    // rdy low blocks accept.
    ex_ready = 1'b1;
    rdy = 1'b0;
    issue(4'd4, 4'd0, 32'd1, 4'd0, 32'd1);
    rdy = 1'b1;
    check("t7_rdy_low_count", count, 0);

    // Asynchronous reset in the middle of a dispatch.
    issue(4'd6, 4'd0, 32'h42, 4'd0, 32'd0);
    tick();
    check("t8_pre_valid", ex_valid, 1);
    check("t8_pre_v1", ex_v1, 32'h42);
    #2 rst = 1'b1;
    #1;
    check("t8_async_valid", ex_valid, 0);
    check("t8_async_v1", ex_v1, 0);
    check("t8_async_dest", ex_dest, 0);
    rst = 1'b0;
    tick();
    check("t8_post_valid", ex_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rs_sched
